// File: rtl/wb_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Round-robin merge of NR_REQ FU results into one writeback port.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int NR_REQ        = 3,
    parameter int TRANS_ID_BITS = 3,
    parameter int XLEN          = 64
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic [NR_REQ-1:0]               req_valid_i,
    output logic [NR_REQ-1:0]               req_ready_o,
    input  logic [NR_REQ*TRANS_ID_BITS-1:0] req_trans_id_i,
    input  logic [NR_REQ*XLEN-1:0]          req_data_i,
    input  logic [NR_REQ-1:0]               req_ex_valid_i,
    input  logic [NR_REQ*XLEN-1:0]          req_ex_cause_i,
    output logic                            wt_valid_o,
    output logic [TRANS_ID_BITS-1:0]        trans_id_o,
    output logic [XLEN-1:0]                 wbdata_o,
    output logic                            ex_valid_o,
    output logic [XLEN-1:0]                 ex_cause_o,
    output logic [31:0]                     conflict_cnt_o
);

    localparam int PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
    localparam logic [PTR_W:0]   NR_REQ_W = (PTR_W+1)'(NR_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NR_REQ - 1);

    logic [NR_REQ-1:0]        full_q;
    logic [TRANS_ID_BITS-1:0] tid_q   [NR_REQ];
    logic [XLEN-1:0]          data_q  [NR_REQ];
    logic [XLEN-1:0]          cause_q [NR_REQ];
    logic [NR_REQ-1:0]        exv_q;

    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [NR_REQ-1:0]        grant;
    logic                     grant_vld;
    logic [PTR_W-1:0]         grant_idx;
    logic [PTR_W:0]           scan_idx;
    logic [NR_REQ-1:0]        accept;

    logic                     wt_valid_q;
    logic [TRANS_ID_BITS-1:0] out_tid_q;
    logic [XLEN-1:0]          out_data_q;
    logic                     out_ex_q;
    logic [XLEN-1:0]          out_cause_q;

    logic [31:0]              conflict_cnt_q, conflict_cnt_d;
    logic                     conflict;

    // Scan from rr_ptr upward with wrap; a flush suppresses the grant so rr_ptr holds.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int off = 0; off < NR_REQ; off++) begin
            scan_idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(off);
            if (scan_idx >= NR_REQ_W) begin
                scan_idx = scan_idx - NR_REQ_W;
            end
            if (!grant_vld && !flush_i && full_q[scan_idx[PTR_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx[PTR_W-1:0];
            end
        end
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        end
    end

    assign req_ready_o = flush_i ? '0 : (~full_q | grant);
    assign accept      = req_valid_i & req_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= '0;
            exv_q  <= '0;
            for (int i = 0; i < NR_REQ; i++) begin
                tid_q[i]   <= '0;
                data_q[i]  <= '0;
                cause_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NR_REQ; i++) begin
                if (flush_i) begin
                    full_q[i] <= 1'b0;
                end else if (accept[i]) begin
                    full_q[i]  <= 1'b1;
                    tid_q[i]   <= req_trans_id_i[i*TRANS_ID_BITS +: TRANS_ID_BITS];
                    data_q[i]  <= req_data_i[i*XLEN +: XLEN];
                    exv_q[i]   <= req_ex_valid_i[i];
                    cause_q[i] <= req_ex_cause_i[i*XLEN +: XLEN];
                end else if (grant[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q    <= '0;
            wt_valid_q  <= 1'b0;
            out_tid_q   <= '0;
            out_data_q  <= '0;
            out_ex_q    <= 1'b0;
            out_cause_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wt_valid_q <= grant_vld;
            if (grant_vld) begin
                out_tid_q   <= tid_q[grant_idx];
                out_data_q  <= data_q[grant_idx];
                out_ex_q    <= exv_q[grant_idx];
                out_cause_q <= cause_q[grant_idx];
            end
        end
    end

    // Clearing the lowest set bit leaves a nonzero value only when two or more are set.
    assign conflict = (full_q & (full_q - 1'b1)) != '0;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (conflict && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign wt_valid_o     = wt_valid_q;
    assign trans_id_o     = out_tid_q;
    assign wbdata_o       = out_data_q;
    assign ex_valid_o     = wt_valid_q & out_ex_q;
    assign ex_cause_o     = out_cause_q;
    assign conflict_cnt_o = conflict_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed scoreboard bench for wb_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int NR = 3;
    localparam int TB = 3;
    localparam int XL = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*TB-1:0] req_tid;
    logic [NR*XL-1:0] req_data;
    logic [NR-1:0]   req_ex;
    logic [NR*XL-1:0] req_cause;
    logic            wt_valid;
    logic [TB-1:0]   trans_id;
    logic [XL-1:0]   wbdata;
    logic            ex_valid;
    logic [XL-1:0]   ex_cause;
    logic [31:0]     conflict_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    typedef struct {
        logic [TB-1:0] tid;
        logic [XL-1:0] data;
        logic          ex;
        logic [XL-1:0] cause;
        int            cyc;
    } exp_t;
    exp_t sbq[$];

    wb_port_arbiter #(.NR_REQ(NR), .TRANS_ID_BITS(TB), .XLEN(XL)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_trans_id_i (req_tid),
        .req_data_i     (req_data),
        .req_ex_valid_i (req_ex),
        .req_ex_cause_i (req_cause),
        .wt_valid_o     (wt_valid),
        .trans_id_o     (trans_id),
        .wbdata_o       (wbdata),
        .ex_valid_o     (ex_valid),
        .ex_cause_o     (ex_cause),
        .conflict_cnt_o (conflict_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    task automatic push(input logic [TB-1:0] t, input logic [XL-1:0] d,
                        input logic e, input logic [XL-1:0] c, input int at);
        exp_t x;
        x.tid = t; x.data = d; x.ex = e; x.cause = c; x.cyc = at;
        sbq.push_back(x);
    endtask

    task automatic set_req(input int i, input logic v, input logic [TB-1:0] t,
                           input logic [XL-1:0] d, input logic e, input logic [XL-1:0] c);
        req_valid[i]           = v;
        req_tid[i*TB +: TB]    = t;
        req_data[i*XL +: XL]   = d;
        req_ex[i]              = e;
        req_cause[i*XL +: XL]  = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, '0, '0, 1'b0, '0);
    endtask

    // Writeback monitor: every output pulse must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (wt_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_wb: got tid %0d data %0h at cycle %0d, required no writeback",
                         trans_id, wbdata, cyc);
            end else begin
                e = sbq.pop_front();
                chk("wb_tid",   64'(trans_id), 64'(e.tid));
                chk("wb_data",  wbdata, e.data);
                chk("wb_ex",    64'(ex_valid), 64'(e.ex));
                chk("wb_cause", ex_cause, e.cause);
                chk("wb_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int k;
        int iter;
        logic acc;

        rst = 1'b1; flush = 1'b0;
        req_valid = '0; req_tid = '0; req_data = '0; req_ex = '0; req_cause = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wt_valid", 64'(wt_valid), 0);
        chk("rst_ex_valid", 64'(ex_valid), 0);
        chk("rst_tid",      64'(trans_id), 0);
        chk("rst_wbdata",   wbdata, 0);
        chk("rst_cause",    ex_cause, 0);
        chk("rst_conflict", 64'(conflict_cnt), 0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 64'(req_ready), 64'h7);
        step();

        // All three sources at once, pointer at 0: drained in index order.
        set_req(0, 1'b1, 3'd1, 64'h11, 1'b0, 64'h0);
        set_req(1, 1'b1, 3'd2, 64'h22, 1'b0, 64'h0);
        set_req(2, 1'b1, 3'd3, 64'h33, 1'b0, 64'h0);
        step();
        a = cyc;
        clear_all();
        push(3'd1, 64'h11, 1'b0, 64'h0, a + 1);
        push(3'd2, 64'h22, 1'b0, 64'h0, a + 2);
        push(3'd3, 64'h33, 1'b0, 64'h0, a + 3);
        repeat (4) step();
        chk("conflict_all3", 64'(conflict_cnt), 2);

        // FU0 streams four results while FU2 holds one.
        a = cyc + 1;
        push(3'd0, 64'hA0, 1'b0, 64'h0, a + 1);
        push(3'd6, 64'hC0, 1'b0, 64'h0, a + 2);
        push(3'd1, 64'hA1, 1'b0, 64'h0, a + 3);
        push(3'd2, 64'hA2, 1'b0, 64'h0, a + 4);
        push(3'd3, 64'hA3, 1'b0, 64'h0, a + 5);
        set_req(2, 1'b1, 3'd6, 64'hC0, 1'b0, 64'h0);
        k = 0;
        iter = 0;
        while (k < 4 && iter < 20) begin
            set_req(0, 1'b1, 3'(k), 64'hA0 + 64'(k), 1'b0, 64'h0);
            acc = req_ready[0];
            step();
            set_req(2, 1'b0, '0, '0, 1'b0, '0);
            if (acc) k++;
            iter++;
        end
        chk("stream_accepts", 64'(k), 4);
        clear_all();
        repeat (4) step();
        chk("conflict_stream", 64'(conflict_cnt), 4);

        // Single source FU1.
        set_req(1, 1'b1, 3'd5, 64'hAB, 1'b0, 64'h0);
        step();
        a = cyc;
        clear_all();
        push(3'd5, 64'hAB, 1'b0, 64'h0, a + 1);
        repeat (3) step();
        chk("conflict_single", 64'(conflict_cnt), 4);
        chk("idle_wt_valid", 64'(wt_valid), 0);

        // Exception from FU2.
        set_req(2, 1'b1, 3'd4, 64'h44, 1'b1, 64'h2);
        step();
        a = cyc;
        clear_all();
        push(3'd4, 64'h44, 1'b1, 64'h2, a + 1);
        step();
        step();
        chk("ex_valid_after", 64'(ex_valid), 0);
        chk("ex_cause_hold",  ex_cause, 64'h2);

        // Flush with two buffers full and one result in the output slot.
        set_req(0, 1'b1, 3'd7, 64'h70, 1'b0, 64'h0);
        set_req(1, 1'b1, 3'd6, 64'h60, 1'b0, 64'h0);
        set_req(2, 1'b1, 3'd5, 64'h50, 1'b0, 64'h0);
        step();
        a = cyc;
        clear_all();
        push(3'd7, 64'h70, 1'b0, 64'h0, a + 1);
        step();
        flush = 1'b1;
        #1;
        chk("ready_during_flush", 64'(req_ready), 0);
        step();
        flush = 1'b0;
        #1;
        chk("wt_valid_after_flush", 64'(wt_valid), 0);
        chk("ready_after_flush", 64'(req_ready), 64'h7);
        repeat (4) step();

        // Asynchronous reset mid-drain (pointer now at 1, so FU1 goes first).
        set_req(0, 1'b1, 3'd1, 64'hD0, 1'b0, 64'h0);
        set_req(1, 1'b1, 3'd2, 64'hD1, 1'b0, 64'h0);
        set_req(2, 1'b1, 3'd3, 64'hD2, 1'b1, 64'h9);
        step();
        clear_all();
        step();
        chk("pre_reset_valid", 64'(wt_valid), 1);
        chk("pre_reset_tid",   64'(trans_id), 2);
        rst = 1'b1;
        #1;
        chk("async_rst_valid",    64'(wt_valid), 0);
        chk("async_rst_tid",      64'(trans_id), 0);
        chk("async_rst_wbdata",   wbdata, 0);
        chk("async_rst_conflict", 64'(conflict_cnt), 0);
        #10;
        rst = 1'b0;
        repeat (5) step();
        chk("post_reset_ready",    64'(req_ready), 64'h7);
        chk("post_reset_conflict", 64'(conflict_cnt), 0);
        chk("scoreboard_empty",    64'(sbq.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
